// File: rtl/counter_jk_pkg.sv
// Shared definitions for the counter_jk block: mode codes and the JK action encoding.
package counter_jk_pkg;

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  // Encoding matches the {J,K} pair, so a cell can cast its inputs directly.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_action_e;

  function automatic logic jk_next(input logic q, input jk_action_e action);
    logic nxt;
    nxt = q;
    case (action)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/counter_jk_cell.sv
// Single JK flip-flop bit with asynchronous active-low clear.
// COUNTER_JK_PRESET_EN adds an asynchronous active-low preset_ (clear_ has priority).
module jk_cell
  import counter_jk_pkg::*;
(
  input  logic clockpulse,
  input  logic clear_,
`ifdef COUNTER_JK_PRESET_EN
  input  logic preset_,
`endif
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_
);

  jk_action_e action;
  assign action = jk_action_e'({j, k});

`ifdef COUNTER_JK_PRESET_EN
  always_ff @(posedge clockpulse or negedge clear_ or negedge preset_) begin
    if (!clear_) begin
      q <= 1'b0;
    end else if (!preset_) begin
      q <= 1'b1;
    end else begin
      q <= jk_next(q, action);
    end
  end
`else
  // NOTE: sequential state uses non-blocking assignments so every cell samples
  // its neighbours' pre-edge values, which the counter and shift chains rely on.
  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) begin
      q <= 1'b0;
    end else begin
      q <= jk_next(q, action);
    end
  end
`endif

  assign q_ = ~q;

endmodule

// File: rtl/counter_jk.sv
// WIDTH-bit JK register/counter: raw JK, up-count, down-count or shift-left per mode.
// Define COUNTER_JK_PRESET_EN to add the asynchronous active-low preset_ port.
module counter_jk
  import counter_jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clockpulse,
  input  logic             clear_,
`ifdef COUNTER_JK_PRESET_EN
  input  logic             preset_,
`endif
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] jack,
  input  logic [WIDTH-1:0] kilby,
  input  logic             serial_in,
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_,
  output logic             terminal
);

  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] ones_below;
  logic [WIDTH-1:0] zeros_below;
  logic [WIDTH-1:0] shift_d;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always does.
  always_comb begin
    logic [WIDTH-1:0] mask;
    mask        = '0;
    ones_below  = '0;
    zeros_below = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask           = (WIDTH'(1) << i) - WIDTH'(1);
      ones_below[i]  = &(signal_q | ~mask);
      zeros_below[i] = ~|(signal_q & mask);
    end
  end

  assign shift_d = {signal_q[WIDTH-2:0], serial_in};

  // NOTE: defaults first so every path assigns j_vec/k_vec and no latch is inferred.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (enable) begin
      case (mode)
        MODE_JK: begin
          j_vec = jack;
          k_vec = kilby;
        end
        MODE_UP: begin
          j_vec = ones_below;
          k_vec = ones_below;
        end
        MODE_DOWN: begin
          j_vec = zeros_below;
          k_vec = zeros_below;
        end
        MODE_SHIFT: begin
          j_vec = shift_d;
          k_vec = ~shift_d;
        end
        default: begin
          j_vec = '0;
          k_vec = '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clockpulse (clockpulse),
      .clear_     (clear_),
`ifdef COUNTER_JK_PRESET_EN
      .preset_    (preset_),
`endif
      .j          (j_vec[i]),
      .k          (k_vec[i]),
      .q          (signal_q[i]),
      .q_         (signal_q_[i])
    );
  end

  // clear_ gates the flag directly so it drops the instant reset asserts.
  assign terminal = clear_ & enable &
                    (((mode == MODE_UP)   & (&signal_q)) |
                     ((mode == MODE_DOWN) & ~(|signal_q)));

endmodule
